// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// Works on operand magnitudes for WIDTH cycles, then a single FIX cycle applies signs and commits.
`timescale 1ns/1ps
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  input  logic             HiWrEn,
  input  logic             LoWrEn,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 start_ok;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v[WIDTH-1]) r = -v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign start_ok = Start && !Flush;

  // Multiply: acc holds {partial_hi, remaining multiplier bits}; add, then shift right one.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  // Divide: shift the next dividend bit into the remainder and restore if it underflows.
  assign div_shift = {rem_q, a_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  assign prod_fix = neg_wide(acc_q, ~op_q[0] & (neg_a_q ^ neg_b_q));
  assign quo_fix  = (b_q == '0) ? '1 : neg_word(a_q, ~op_q[0] & (neg_a_q ^ neg_b_q));
  assign rem_fix  = neg_word(rem_q, ~op_q[0] & neg_a_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = Op[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:   if (Flush) state_d = S_IDLE;
               else if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d    = Op;
          neg_a_d = ~Op[0] & SrcA[WIDTH-1];
          neg_b_d = ~Op[0] & SrcB[WIDTH-1];
          a_d     = mag($signed(SrcA), ~Op[0]);
          b_d     = mag($signed(SrcB), ~Op[0]);
          acc_d   = {{WIDTH{1'b0}}, b_d};
          rem_d   = '0;
          cnt_d   = '0;
        end else if (!Flush) begin
          if (HiWrEn) hi_d = WrData;
          if (LoWrEn) lo_d = WrData;
        end
      end
      S_MUL: begin
        if (!Flush) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (!Flush) begin
          rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        if (!Flush) begin
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed corner cases plus random operations against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Flush = 1'b0;
  logic         HiWrEn = 1'b0;
  logic         LoWrEn = 1'b0;
  logic [W-1:0] WrData = '0;
  logic [W-1:0] Hi, Lo;
  logic         Busy, Done;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_hilo_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .HiWrEn(HiWrEn), .LoWrEn(LoWrEn), .WrData(WrData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Reference: plain 64-bit arithmetic with the architectural divide corner cases.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = (op == 2'b00) ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
    if (!op[1]) begin
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'h0) begin
      hi = a; lo = 32'hFFFF_FFFF;
    end else if (op == 2'b10) begin
      sq = sa / sb; sr = sa % sb;
      hi = sr[31:0]; lo = sq[31:0];
    end else begin
      hi = a % b; lo = a / b;
    end
  endfunction

  // Launch at the current negedge, scramble operands afterwards, wait for Done (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bsy, output logic [31:0] hi, output logic [31:0] lo);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
    lat = 0; bsy = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy === 1'b1) bsy++;
      @(negedge clk);
      lat++;
    end
    hi = Hi; lo = Lo;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (Hi !== 32'h0)  begin n_bad++; $display("FAIL reset_hi got=%h exp=0", Hi); end
    n_cmp++; if (Lo !== 32'h0)  begin n_bad++; $display("FAIL reset_lo got=%h exp=0", Lo); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat, bsy; logic [31:0] hi, lo;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bsy, hi, lo);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    n_cmp++; if (bsy !== 33) begin n_bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", bsy); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, hi, lo);
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_max_hi got=%h exp=fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_max_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div;
    int lat, bsy; logic [31:0] hi, lo;
    run_op(2'b11, 32'd100, 32'd7, lat, bsy, hi, lo);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
    n_cmp++; if (hi !== 32'd2)  begin n_bad++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bsy, hi, lo);
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_negdvd_lo got=%h exp=fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_negdvd_hi got=%h exp=ffffffff", hi); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bsy, hi, lo);
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_negdvs_lo got=%h exp=fffffffd", lo); end
    n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL div_negdvs_hi got=%h exp=00000001", hi); end
  endtask

  task automatic test_div_special;
    int lat, bsy; logic [31:0] hi, lo;
    run_op(2'b10, 32'd5, 32'd0, lat, bsy, hi, lo);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divzero_latency got=%0d exp=33", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divzero_lo got=%h exp=ffffffff", lo); end
    n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL divzero_hi got=%h exp=00000005", hi); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy, hi, lo);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_hilo_write;
    int n;
    HiWrEn = 1'b1; LoWrEn = 1'b1; WrData = 32'hA5A5_A5A5;
    @(negedge clk);
    HiWrEn = 1'b0; LoWrEn = 1'b0;
    n_cmp++; if (Hi !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL mthi_both got=%h exp=a5a5a5a5", Hi); end
    n_cmp++; if (Lo !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL mtlo_both got=%h exp=a5a5a5a5", Lo); end
    Op = 2'b01; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1; LoWrEn = 1'b1; WrData = 32'hDEAD_BEEF;
    @(negedge clk);
    Start = 1'b0; LoWrEn = 1'b0;
    n_cmp++; if (Lo !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL start_lowren_lo got=%h exp=a5a5a5a5", Lo); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL start_lowren_busy got=%b exp=1", Busy); end
    n = 0;
    while (Done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (Lo !== 32'd15) begin n_bad++; $display("FAIL start_lowren_result got=%h exp=0000000f", Lo); end
    HiWrEn = 1'b1; WrData = 32'h0000_1234;
    @(negedge clk);
    HiWrEn = 1'b0;
    n_cmp++; if (Hi !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi got=%h exp=00001234", Hi); end
    n_cmp++; if (Lo !== 32'd15) begin n_bad++; $display("FAIL mthi_lo_kept got=%h exp=0000000f", Lo); end
  endtask

  task automatic test_flush;
    int dones;
    Op = 2'b00; SrcA = $urandom; SrcB = $urandom; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b exp=0", Busy); end
    dones = 0;
    repeat (40) begin if (Done === 1'b1) dones++; @(negedge clk); end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    n_cmp++; if (Hi !== 32'h0000_1234) begin n_bad++; $display("FAIL flush_hi got=%h exp=00001234", Hi); end
    Flush = 1'b1; Start = 1'b1; HiWrEn = 1'b1; WrData = 32'h0000_BEEF;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0; HiWrEn = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_flush_start got=%b exp=0", Busy); end
    n_cmp++; if (Hi !== 32'h0000_1234) begin n_bad++; $display("FAIL idle_flush_write got=%h exp=00001234", Hi); end
    Op = 2'b01; SrcA = 32'd2; SrcB = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (32) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL fix_flush_done got=%b exp=0", Done); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL fix_flush_busy got=%b exp=0", Busy); end
    n_cmp++; if (Lo !== 32'd15) begin n_bad++; $display("FAIL fix_flush_lo got=%h exp=0000000f", Lo); end
  endtask

  task automatic test_reset_mid;
    Op = 2'b11; SrcA = $urandom; SrcB = $urandom | 32'h1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (Hi !== 32'h0) begin n_bad++; $display("FAIL midreset_hi got=%h exp=0", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_bad++; $display("FAIL midreset_lo got=%h exp=0", Lo); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bsy; logic [31:0] hi, lo, eh, el;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    run_op(2'b00, a1, b1, lat, bsy, hi, lo);
    ref_model(2'b00, a1, b1, eh, el);
    n_cmp++; if ({hi, lo} !== {eh, el}) begin n_bad++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi, lo, eh, el); end
    run_op(2'b10, a2, b2, lat, bsy, hi, lo);
    ref_model(2'b10, a2, b2, eh, el);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    n_cmp++; if ({hi, lo} !== {eh, el}) begin n_bad++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_busy_ignore;
    int n; logic [31:0] a, b, eh, el, hi0;
    a = $urandom; b = $urandom_range(1, 65535);
    hi0 = Hi;
    ref_model(2'b11, a, b, eh, el);
    Op = 2'b11; SrcA = a; SrcB = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    repeat (5) begin @(negedge clk); n++; end
    Start = 1'b1; Op = 2'b00; SrcA = $urandom; SrcB = $urandom;
    HiWrEn = 1'b1; LoWrEn = 1'b1; WrData = 32'h5555_5555;
    @(negedge clk); n++;
    Start = 1'b0; HiWrEn = 1'b0; LoWrEn = 1'b0;
    n_cmp++; if (Hi !== hi0) begin n_bad++; $display("FAIL busy_write_hi got=%h exp=%h", Hi, hi0); end
    while (Done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL busy_start_latency got=%0d exp=33", n); end
    n_cmp++; if ({Hi, Lo} !== {eh, el}) begin n_bad++; $display("FAIL busy_start_result got=%h_%h exp=%h_%h", Hi, Lo, eh, el); end
  endtask

  task automatic test_random;
    int lat, bsy; logic [31:0] a, b, hi, lo, eh, el; logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = 32'($signed(-$urandom_range(1, 20)));
        default: ;
      endcase
      run_op(op, a, b, lat, bsy, hi, lo);
      ref_model(op, a, b, eh, el);
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL rand_latency[%0d] got=%0d exp=33", i, lat); end
      n_cmp++; if ({hi, lo} !== {eh, el}) begin
        n_bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, hi, lo, eh, el);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_hilo_write();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
